// File: rtl/button_events.sv
`timescale 1ns/1ps
// Gesture classifier for a debounced button level: emits one-cycle press, release,
// click, double-click and long-press events plus a held level, all registered.
module button_events #(
  parameter int LONG_PERIOD = 500000,
  parameter int GAP_PERIOD  = 150000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_double,
  output logic o_long,
  output logic o_held
);

  localparam int MAXP = (LONG_PERIOD > GAP_PERIOD) ? LONG_PERIOD : GAP_PERIOD;
  localparam int CW   = $clog2(MAXP + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, LONG} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          prev_q;
  logic          press_q, release_q, click_q, double_q, long_q, held_q;

  logic          rise_d, fall_d;
  logic [CW-1:0] cnt_d;

  assign rise_d = i_level & ~prev_q;
  assign fall_d = ~i_level & prev_q;
  assign cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // The counter holds (edges spent in the current timed state - 1), so a
  // threshold of N edges is reached when it reads N-1 on the Nth edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      prev_q    <= i_level;
      press_q   <= rise_d;
      release_q <= fall_d;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_d) begin
            state_q <= PRESS1;
            cnt_q   <= '0;
            held_q  <= 1'b1;
          end
        end
        PRESS1: begin
          if (fall_d) begin
            state_q <= GAP;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end else if (cnt_q == LONG_LAST) begin
            state_q <= LONG;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        GAP: begin
          if (rise_d) begin
            state_q <= PRESS2;
            cnt_q   <= '0;
            held_q  <= 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            click_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        PRESS2: begin
          if (fall_d) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            held_q   <= 1'b0;
            double_q <= 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_q <= LONG;
            cnt_q   <= '0;
            click_q <= 1'b1;
            long_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        LONG: begin
          if (fall_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_double  = double_q;
  assign o_long    = long_q;
  assign o_held    = held_q;

endmodule

// File: tb/tb_button_events.sv
`timescale 1ns/1ps
// Bench for button_events: timestamp-based gesture model compared every cycle,
// directed gesture scenarios with literal latency/count expectations, random levels.
module tb_button_events;

  localparam int LP = 8;
  localparam int GP = 5;

  logic clk = 1'b0;
  logic rst;
  logic lvl;
  logic o_press, o_release, o_click, o_double, o_long, o_held;

  always #5 clk = ~clk;

  button_events #(.LONG_PERIOD(LP), .GAP_PERIOD(GP)) dut (
    .i_clk(clk), .i_rst(rst), .i_level(lvl),
    .o_press(o_press), .o_release(o_release), .o_click(o_click),
    .o_double(o_double), .o_long(o_long), .o_held(o_held)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Gesture model: tracks how many presses are in the gesture and the edge
  // index of the last rise/fall, deciding events from elapsed edge counts.
  int m_n, m_presses, m_trise, m_tfall;
  bit m_prev, m_long;
  bit e_press, e_release, e_click, e_double, e_long, e_held;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_presses = 0; m_trise = 0; m_tfall = 0; m_prev = 0; m_long = 0;
      e_press = 0; e_release = 0; e_click = 0; e_double = 0; e_long = 0; e_held = 0;
    end else begin
      m_n++;
      e_press   = lvl && !m_prev;
      e_release = !lvl && m_prev;
      e_click = 0; e_double = 0; e_long = 0;
      if (m_long) begin
        if (e_release) begin m_long = 0; m_presses = 0; end
      end else if (m_presses == 0) begin
        if (e_press) begin m_presses = 1; m_trise = m_n; end
      end else if (m_prev) begin
        if (e_release) begin
          if (m_presses == 1) m_tfall = m_n;
          else begin e_double = 1; m_presses = 0; end
        end else if (m_n - m_trise == LP) begin
          e_long = 1; e_click = (m_presses == 2); m_long = 1;
        end
      end else begin
        if (e_press) begin m_presses = 2; m_trise = m_n; end
        else if (m_n - m_tfall == GP) begin e_click = 1; m_presses = 0; end
      end
      m_prev = lvl;
      e_held = m_long || (m_presses > 0 && lvl);
    end
  end

  always @(posedge clk) cyc++;

  int press_cnt = 0, release_cnt = 0, click_cnt = 0, double_cnt = 0, long_cnt = 0;
  int press_cyc = 0, release_cyc = 0, click_cyc = 0, double_cyc = 0, long_cyc = 0;

  always @(negedge clk) begin
    check("press",   o_press,   e_press);
    check("release", o_release, e_release);
    check("click",   o_click,   e_click);
    check("double",  o_double,  e_double);
    check("long",    o_long,    e_long);
    check("held",    o_held,    e_held);
    if (o_press)   begin press_cnt++;   press_cyc   = cyc; end
    if (o_release) begin release_cnt++; release_cyc = cyc; end
    if (o_click)   begin click_cnt++;   click_cyc   = cyc; end
    if (o_double)  begin double_cnt++;  double_cyc  = cyc; end
    if (o_long)    begin long_cnt++;    long_cyc    = cyc; end
  end

  int s_press, s_release, s_click, s_double, s_long;

  task automatic snap();
    s_press = press_cnt; s_release = release_cnt; s_click = click_cnt;
    s_double = double_cnt; s_long = long_cnt;
  endtask

  task automatic drive(input logic v, input int n);
    lvl = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_counts(input string nm, input int p, input int r, input int c,
                               input int d, input int l);
    #2;
    check({nm, "_npress"},   press_cnt - s_press,     p);
    check({nm, "_nrelease"}, release_cnt - s_release, r);
    check({nm, "_nclick"},   click_cnt - s_click,     c);
    check({nm, "_ndouble"},  double_cnt - s_double,   d);
    check({nm, "_nlong"},    long_cnt - s_long,       l);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_press"},   o_press,   0);
    check({nm, "_release"}, o_release, 0);
    check({nm, "_click"},   o_click,   0);
    check({nm, "_double"},  o_double,  0);
    check({nm, "_long"},    o_long,    0);
    check({nm, "_held"},    o_held,    0);
  endtask

  initial begin
    rst = 1'b1;
    lvl = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("rst");
    @(negedge clk); #3 rst = 1'b0;
    @(negedge clk);
    drive(0, 3);

    // Single click
    snap(); drive(1, 3); drive(0, 8);
    expect_counts("single", 1, 1, 1, 0, 0);
    check("single_click_lat", click_cyc - release_cyc, GP);

    // Double click
    snap(); drive(1, 3); drive(0, 2); drive(1, 3); drive(0, 8);
    expect_counts("double", 2, 2, 0, 1, 0);
    check("double_same_cyc", double_cyc, release_cyc);

    // Second rise sampled on gap edge 5: still a double
    snap(); drive(1, 3); drive(0, 5); drive(1, 3); drive(0, 8);
    expect_counts("gap5", 2, 2, 0, 1, 0);

    // Second rise on gap edge 6: click first, then a fresh single press
    snap(); drive(1, 3); drive(0, 6); drive(1, 3); drive(0, 8);
    expect_counts("gap6", 2, 2, 2, 0, 0);

    // Long press
    snap(); drive(1, 20); drive(0, 8);
    expect_counts("long", 1, 1, 0, 0, 1);
    check("long_lat", long_cyc - press_cyc, LP);

    // Fall sampled on edge 8 is still short
    snap(); drive(1, 8); drive(0, 8);
    expect_counts("short8", 1, 1, 1, 0, 0);

    // High through edge 8 is long
    snap(); drive(1, 9); drive(0, 8);
    expect_counts("long9", 1, 1, 0, 0, 1);

    // Click then long: click and long together
    snap(); drive(1, 2); drive(0, 2); drive(1, 12); drive(0, 8);
    expect_counts("clicklong", 2, 2, 1, 0, 1);
    check("clicklong_same", click_cyc, long_cyc);
    check("clicklong_lat", long_cyc - press_cyc, LP);

    // Reset mid-gap with level high at deassertion
    snap(); drive(1, 3); drive(0, 2);
    #3 rst = 1'b1;
    #1 check_all_zero("rstgap");
    lvl = 1'b1;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    drive(1, 12); drive(0, 8);
    expect_counts("rstgap", 2, 2, 0, 0, 1);
    check("rstgap_long_lat", long_cyc - press_cyc, LP);

    // Reset mid-hold drops held immediately
    snap(); drive(1, 5);
    #1 check("hold_before_rst", o_held, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("rsthold");
    lvl = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    drive(0, 10);
    expect_counts("rsthold", 1, 0, 0, 0, 0);

    // Random levels with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        #3 rst = 1'b1;
        lvl = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
      end else begin
        drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end
    end
    drive(0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Classifies button gestures from the debouncer's clean, synchronous level output. It emits single-cycle event pulses for press, release, single click, double click and long press. It sits directly downstream of the debouncer and feeds the control logic, which only ever sees one-cycle events.

## Interface
- LONG_PERIOD, default 500000: cycles a press must be held to count as a long press; legal range ≥ 2.
- GAP_PERIOD, default 150000: maximum release-to-press gap, in cycles, for a double click; legal range ≥ 1.
- i_clk  input  1  sole clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_level  input  1  debounced button level from the debouncer, synchronous to i_clk; 1 = pressed.
- o_press  output  1  one-cycle pulse on every 0→1 of i_level.
- o_release  output  1  one-cycle pulse on every 1→0 of i_level.
- o_click  output  1  one-cycle pulse when a single short press is confirmed.
- o_double  output  1  one-cycle pulse when a double click completes.
- o_long  output  1  one-cycle pulse when a hold reaches LONG_PERIOD.
- o_held  output  1  level; 1 while the FSM is in any pressed state.

## Operation
- Edge detection: r_prev holds i_level from the previous edge. A rise is i_level=1 with r_prev=0; a fall is i_level=0 with r_prev=1.
- One counter of width $clog2(max(LONG_PERIOD, GAP_PERIOD)+1).
  - Cleared on every state change.
  - Increments once per edge while in a timed state.
  - Saturates and never wraps.
- FSM states and transitions:
  - IDLE: a rise goes to PRESS1.
  - PRESS1: a fall before the long threshold goes to GAP. Reaching the threshold pulses o_long and goes to LONG.
  - GAP: a rise within GAP_PERIOD edges after the release goes to PRESS2. If GAP_PERIOD edges elapse with no rise, pulse o_click and go to IDLE.
  - PRESS2: a fall before the long threshold pulses o_double and goes to IDLE. Reaching the threshold pulses o_click and o_long in the same cycle and goes to LONG.
  - LONG: a fall goes to IDLE. No click or double event is produced.
- o_press and o_release fire on every rise and fall, in every state, in addition to any gesture event.
- o_held = 1 in PRESS1, PRESS2 and LONG; 0 in IDLE and GAP.
- Event ordering: o_click, o_double and o_long can never be high in the same cycle, except o_click+o_long on a PRESS2 long hold.
- Reset, including mid-gesture: state goes to IDLE, the counter to 0, r_prev to 0, and every output to 0. Any gesture in progress is discarded with no event.
  - Because r_prev resets to 0, if i_level is 1 when i_rst deasserts, the first edge sees a rise: o_press pulses and the FSM enters PRESS1.

## Timing
- All outputs are registered. A pulse is high for exactly one cycle, following the edge on which its condition was sampled.
- o_press / o_release: high during the cycle after the edge that samples the rise / fall. Latency is 1 edge.
- Long threshold: rise sampled at edge 0 and i_level high at edges 1..LONG_PERIOD. o_long is high after edge LONG_PERIOD, i.e. exactly LONG_PERIOD cycles after o_press.
  - A fall sampled at any edge 1..LONG_PERIOD is a short press.
- Gap: fall sampled at edge r.
  - A rise sampled at edges r+1..r+GAP_PERIOD is a second press.
  - Otherwise o_click is high after edge r+GAP_PERIOD. Click latency from release is GAP_PERIOD cycles.
- o_double is high after the edge sampling the second fall, in the same cycle as that o_release.
- Back-to-back gestures: IDLE accepts a rise on the edge immediately after any return to IDLE. No dead cycle is required.
- Asynchronous reset clears outputs immediately, not at the next clock edge.

## Test plan
Bench parameters: LONG_PERIOD=8, GAP_PERIOD=5.
- Single click: i_level high 3 cycles, then low for ≥ 6 → o_press ×1, o_release ×1, then o_click ×1 exactly 5 cycles after o_release. No o_double or o_long.
- Double click: high 3, low 2, high 3, low → o_press ×2, o_release ×2, o_double ×1 in the cycle of the second o_release. No o_click.
- Gap boundary: release, then rise sampled on gap edge 5 → double path. Rise sampled on edge 6 → o_click after edge 5, then a new PRESS1 with o_press.
- Long press: high 20 cycles → o_long ×1 exactly 8 cycles after o_press, o_held=1 throughout, o_release on fall, no click. Repeat with high for exactly 8 edges after the rise → short press, no o_long.
- Click then long: high 2, low 2, high 12 → o_click and o_long in the same single cycle, 8 cycles after the second o_press.
- Reset: assert i_rst mid-GAP → all outputs 0 at once, no o_click later. Deassert reset with i_level=1 → o_press after the first edge, then o_long 8 cycles later.
